pe_sched: RTL and testbench

//  Host-side command scheduler for the shared serial control line of the PE array.

---
 rtl/pe_pkg.sv | 43 ++++
 rtl/pe_cmd_fifo.sv | 59 +++++
 rtl/pe_sched.sv | 196 +++++++++++++++++++
 tb/tb_pe_sched.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// ----------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the PE array control line: opcode values (common to
// pe_sched and pctrl), the scheduler FSM state encoding, frame geometry and
// the packed command record carried through the command FIFO.
// ----------------------------------------------------------------------------
package pe_pkg;

   // Opcodes carried in the OPF field; NO_OP is never put on the line.
   localparam logic [2:0] OUT_DATA1 = 3'd0;
   localparam logic [2:0] OUT_DATA2 = 3'd1;
   localparam logic [2:0] OUT_RES   = 3'd2;
   localparam logic [2:0] LOAD      = 3'd3;
   localparam logic [2:0] ADD       = 3'd4;
   localparam logic [2:0] MUL       = 3'd5;
   localparam logic [2:0] MUL_ADD   = 3'd6;
   localparam logic [2:0] NO_OP     = 3'd7;

   // Frame geometry: start bit + 8 address bits + 7-bit opcode field.
   localparam int FRAME_BITS = 16;
   localparam int OPF_BITS   = 7;
   localparam int ADDR_BITS  = 8;
   localparam int CMD_W      = ADDR_BITS + 3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_ADDR  = 3'd2,
      ST_OPF   = 3'd3,
      ST_GUARD = 3'd4
   } state_e;

   typedef struct packed {
      logic [ADDR_BITS-1:0] addr;
      logic [2:0]           op;
   } cmd_t;

   // Everything after the start bit, LSB first: address, then {000, op, 0}.
   function automatic logic [FRAME_BITS-2:0] frame_tail(input cmd_t c);
      return {3'b000, c.op, 1'b0, c.addr};
   endfunction

endpackage

// File: rtl/pe_cmd_fifo.sv
// ----------------------------------------------------------------------------
// pe_cmd_fifo
// Small first-word-fall-through command FIFO. The head entry is visible on
// rdata_o whenever empty_o is low so the scheduler can inspect the opcode
// before deciding whether to drop or transmit it.
// Pointers are log2(DEPTH)+1 bits; full/empty are decided by the extra MSB.
// Ports:
//   clk, nRst        clock, asynchronous active-low reset
//   push_i, wdata_i  write request / data (ignored while full, even if a pop
//                    happens in the same cycle)
//   pop_i            remove head (ignored while empty)
//   rdata_o          current head entry
//   full_o, empty_o  status
// ----------------------------------------------------------------------------
module pe_cmd_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             nRst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wptr_q, rptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                    (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
      end
   end

   // Storage needs no reset: only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end

   assign rdata_o = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/pe_sched.sv
// ----------------------------------------------------------------------------
// pe_sched
// Host-side scheduler for the shared serial control line of the PE array.
// Commands {addr, op} are queued and each is sent on tx as one frame:
// start bit (0), 8 address bits LSB first, then the 7-bit field {000,op,0}
// LSB first. Each frame is followed by an idle-high guard window (GUARD
// cycles, or GUARD_RES after OUT_RES) so only one PE executes at a time.
// NO_OP commands are discarded in one cycle without touching the line.
//
// Ports:
//   clk, nRst            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (cmd_ready = FIFO not full)
//   cmd_addr, cmd_op     command contents, captured at push
//   tx                   registered serial line, idle high
//   busy                 FSM active or commands pending
//   res_win              high for the whole guard window after OUT_RES
//   done                 pulse on the last guard cycle of every frame
// Optional (macro PE_SCHED_STATS_EN):
//   frame_cnt[15:0]      frames completed, wraps
//   drop_cnt[7:0]        NO_OPs discarded, saturates at 0xFF
// ----------------------------------------------------------------------------
module pe_sched
   import pe_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int GUARD     = 32,
   parameter int GUARD_RES = 128
) (
   input  logic       clk,
   input  logic       nRst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_addr,
   input  logic [2:0] cmd_op,
   output logic       tx,
   output logic       busy,
   output logic       res_win,
   output logic       done
`ifdef PE_SCHED_STATS_EN
   ,
   output logic [15:0] frame_cnt,
   output logic [7:0]  drop_cnt
`endif
);

   // ---------------------------------------------------------------- FIFO
   logic             fifo_full, fifo_empty;
   logic [CMD_W-1:0] fifo_rdata;
   logic             pop;
   cmd_t             head;

   pe_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .nRst    (nRst),
      .push_i  (cmd_valid),
      .wdata_i ({cmd_addr, cmd_op}),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign head = cmd_t'(fifo_rdata);

   // ------------------------------------------------------------ FSM state
   state_e                  state_q, state_d;
   logic                    tx_q, tx_d;
   logic [FRAME_BITS-2:0]   sh_q, sh_d;      // bits still to send after tx_q
   logic [3:0]              bit_q, bit_d;    // position within ADDR / OPF
   logic [7:0]              guard_q, guard_d;
   logic                    res_q, res_d;    // current frame is OUT_RES
   logic                    launch;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q <= ST_IDLE;
         tx_q    <= 1'b1;
         sh_q    <= '1;
         bit_q   <= '0;
         guard_q <= '0;
         res_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         sh_q    <= sh_d;
         bit_q   <= bit_d;
         guard_q <= guard_d;
         res_q   <= res_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      sh_d    = sh_q;
      bit_d   = bit_q;
      guard_d = guard_q;
      res_d   = res_q;
      launch  = 1'b0;
      pop     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            launch = !fifo_empty;
         end
         ST_START: begin
            state_d = ST_ADDR;
            tx_d    = sh_q[0];
            sh_d    = {1'b1, sh_q[FRAME_BITS-2:1]};
            bit_d   = '0;
         end
         ST_ADDR: begin
            // The shift register already holds the OPF field behind the
            // address, so the last address cycle loads OPF bit 0 naturally.
            tx_d = sh_q[0];
            sh_d = {1'b1, sh_q[FRAME_BITS-2:1]};
            if (bit_q == 4'(ADDR_BITS - 1)) begin
               state_d = ST_OPF;
               bit_d   = '0;
            end else begin
               bit_d = bit_q + 4'd1;
            end
         end
         ST_OPF: begin
            if (bit_q == 4'(OPF_BITS - 1)) begin
               state_d = ST_GUARD;
               tx_d    = 1'b1;
               guard_d = res_q ? 8'(GUARD_RES - 1) : 8'(GUARD - 1);
            end else begin
               tx_d  = sh_q[0];
               sh_d  = {1'b1, sh_q[FRAME_BITS-2:1]};
               bit_d = bit_q + 4'd1;
            end
         end
         ST_GUARD: begin
            if (guard_q == 8'd0) begin
               // Last guard cycle doubles as an IDLE cycle so the next
               // frame's start bit follows without a gap.
               state_d = ST_IDLE;
               launch  = !fifo_empty;
            end else begin
               guard_d = guard_q - 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase

      if (launch) begin
         pop = 1'b1;
         if (head.op == NO_OP) begin
            state_d = ST_IDLE;
         end else begin
            state_d = ST_START;
            tx_d    = 1'b0;
            sh_d    = frame_tail(head);
            res_d   = (head.op == OUT_RES);
         end
      end
   end

   // -------------------------------------------------------------- outputs
   assign tx        = tx_q;
   assign cmd_ready = !fifo_full;
   assign busy      = (state_q != ST_IDLE) || !fifo_empty;
   assign res_win   = (state_q == ST_GUARD) && res_q;
   assign done      = (state_q == ST_GUARD) && (guard_q == 8'd0);

`ifdef PE_SCHED_STATS_EN
   // ---------------------------------------------------------- statistics
   logic [15:0] frame_cnt_q;
   logic [7:0]  drop_cnt_q;
   logic        drop;

   assign drop = pop && (head.op == NO_OP);

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         if (done) frame_cnt_q <= frame_cnt_q + 16'd1;
         if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pe_sched.sv
// ----------------------------------------------------------------------------
// tb_pe_sched
// Self-checking bench for pe_sched. A cycle-position model (command queue +
// "where are we in the current frame") predicts every output each cycle; a
// line receiver decodes frames from tx and matches them against the commands
// the model launched. Directed scenarios pin the model with literal values.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pe_sched;
   import pe_pkg::*;

   localparam int DEPTH     = 4;
   localparam int GUARD     = 32;
   localparam int GUARD_RES = 128;

   logic       clk       = 1'b0;
   logic       nRst      = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [7:0] cmd_addr  = '0;
   logic [2:0] cmd_op    = '0;
   logic       cmd_ready, tx, busy, res_win, done;
`ifdef PE_SCHED_STATS_EN
   logic [15:0] frame_cnt;
   logic [7:0]  drop_cnt;
`endif

   pe_sched #(
      .DEPTH     (DEPTH),
      .GUARD     (GUARD),
      .GUARD_RES (GUARD_RES)
   ) dut (
      .clk       (clk),
      .nRst      (nRst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_op    (cmd_op),
      .tx        (tx),
      .busy      (busy),
      .res_win   (res_win),
      .done      (done)
`ifdef PE_SCHED_STATS_EN
      ,
      .frame_cnt (frame_cnt),
      .drop_cnt  (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc_cnt  = 0;

   always @(posedge clk) cyc_cnt++;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ------------------------------------------------------------ model
   logic [10:0] m_q[$];
   logic [10:0] rx_exp[$];
   int          m_pos    = -1;     // cycle index in current frame, -1 = none
   int          m_len    = 48;
   logic [15:0] m_frame  = '1;
   logic        m_res    = 1'b0;
   int          m_frames = 0;
   int          m_drops  = 0;

   always @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         m_q.delete();
         rx_exp.delete();
         m_pos    = -1;
         m_res    = 1'b0;
         m_frames = 0;
         m_drops  = 0;
      end else begin
         int          cnt;
         logic [10:0] hd;
         cnt = m_q.size();
         if (m_pos == m_len - 1) begin
            m_pos    = -1;
            m_frames = (m_frames + 1) % 65536;
         end else if (m_pos >= 0) begin
            m_pos++;
         end
         if (m_pos < 0 && cnt > 0) begin
            hd = m_q.pop_front();
            if (hd[2:0] == 3'd7) begin
               if (m_drops < 255) m_drops++;
            end else begin
               m_pos   = 0;
               m_frame = {3'b000, hd[2:0], 1'b0, hd[10:3], 1'b0};
               m_res   = (hd[2:0] == 3'd2);
               m_len   = 16 + (m_res ? GUARD_RES : GUARD);
               rx_exp.push_back(hd);
            end
         end
         if (cmd_valid && cnt < DEPTH) m_q.push_back({cmd_addr, cmd_op});
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (nRst) begin
         int exp_tx;
         exp_tx = (m_pos >= 0 && m_pos < 16) ? int'(m_frame[m_pos]) : 1;
         chk("tx", tx, exp_tx);
         chk("cmd_ready", cmd_ready, (m_q.size() < DEPTH) ? 1 : 0);
         chk("busy", busy, (m_pos >= 0 || m_q.size() > 0) ? 1 : 0);
         chk("res_win", res_win, (m_pos >= 16 && m_res) ? 1 : 0);
         chk("done", done, (m_pos >= 0 && m_pos == m_len - 1) ? 1 : 0);
`ifdef PE_SCHED_STATS_EN
         chk("frame_cnt", frame_cnt, m_frames);
         chk("drop_cnt", drop_cnt, m_drops);
`endif
      end
   end

   // ---------------------------------------------------------- receiver
   int          rx_n      = -1;
   int          rx_frames = 0;
   logic [14:0] rx_bits   = '0;

   always @(negedge clk or negedge nRst) begin
      if (!nRst) begin
         rx_n = -1;
      end else if (rx_n < 0) begin
         if (tx == 1'b0) rx_n = 0;
      end else begin
         rx_bits[rx_n] = tx;
         rx_n++;
         if (rx_n == 15) begin
            logic [10:0] e;
            rx_n = -1;
            rx_frames++;
            if (rx_exp.size() == 0) begin
               chk("rx_unexpected_frame", 1, 0);
            end else begin
               e = rx_exp.pop_front();
               chk("rx_addr", rx_bits[7:0], e[10:3]);
               chk("rx_op", rx_bits[11:9], e[2:0]);
               chk("rx_pad", {rx_bits[14:12], rx_bits[8]}, 0);
            end
         end
      end
   end

   // ----------------------------------------------------------- drivers
   // Called at posedge+2; returns at posedge+2 after the accepting edge.
   task automatic push(input logic [7:0] a, input logic [2:0] op, output int waited);
      bit acc;
      acc      = 1'b0;
      waited   = 0;
      cmd_addr = a;
      cmd_op   = op;
      cmd_valid = 1'b1;
      while (!acc && waited < 400) begin
         acc = cmd_ready;
         @(posedge clk); #2;
         waited++;
      end
      cmd_valid = 1'b0;
      cmd_addr  = 8'($urandom);
      cmd_op    = 3'($urandom);
      if (!acc) chk("push_timeout", 0, 1);
   endtask

   task automatic wait_tx_low(input int bound, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tx !== 1'b0 && n < bound);
      chk("tx_low_wait", tx, 0);
   endtask

   // Starts at the negedge showing the start bit (cycle 1).
   task automatic observe_frame(input int bound, output int done_cyc, output int rw_cnt,
                                output int rw_first, output logic [15:0] bits);
      int cyc;
      cyc      = 1;
      done_cyc = 0;
      rw_cnt   = 0;
      rw_first = 0;
      bits     = '0;
      bits[0]  = tx;
      while (done_cyc == 0 && cyc < bound) begin
         @(negedge clk);
         cyc++;
         if (cyc <= 16) bits[cyc-1] = tx;
         if (res_win) begin
            rw_cnt++;
            if (rw_first == 0) rw_first = cyc;
         end
         if (done) done_cyc = cyc;
      end
   endtask

   task automatic wait_idle(input int bound);
      int n;
      n = 0;
      while (busy && n < bound) begin
         @(posedge clk); #2;
         n++;
      end
      chk("idle_wait_busy", busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------- stimulus
   initial begin
      int          w, n, dc, rw, rf, c0, rx0;
      logic [15:0] bits;
`ifdef PE_SCHED_STATS_EN
      int          fc0, dr0;
`endif

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx", tx, 1);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_res_win", res_win, 0);
      chk("rst_done", done, 0);
      @(posedge clk); #2;
      nRst = 1'b1;
      @(posedge clk); #2;

      // MUL to 0x05: latency, exact bit pattern, guard length
      push(8'h05, MUL, w);
      wait_tx_low(10, n);
      chk("t2_latency_negedges", n, 2);
      observe_frame(100, dc, rw, rf, bits);
      chk("t2_bits", bits, 16'h140A);
      chk("t2_done_cycle", dc, 48);
      chk("t2_res_win_cycles", rw, 0);
      @(posedge clk); #2;
      wait_idle(50);

      // OUT_RES to 0x10: long result window
      push(8'h10, OUT_RES, w);
      wait_tx_low(10, n);
      observe_frame(400, dc, rw, rf, bits);
      chk("t3_bits", bits, 16'h0820);
      chk("t3_res_win_cycles", rw, 128);
      chk("t3_res_win_first", rf, 17);
      chk("t3_done_cycle", dc, 144);
      @(posedge clk); #2;
      wait_idle(50);

      // Back-to-back: fill FIFO behind an in-flight frame
      rx0 = rx_frames;
      push(8'h20, ADD, w);
      push(8'h30, OUT_DATA1, w);
      push(8'h31, OUT_DATA2, w);
      push(8'h32, LOAD, w);
      push(8'h33, ADD, w);
      chk("t4_ready_after_4th", cmd_ready, 0);
      push(8'h34, MUL_ADD, w);
      chk("t4_5th_stalled", (w > 10) ? 1 : 0, 1);
      wait_idle(2000);
      chk("t4_frames_sent", rx_frames - rx0, 6);

      // NO_OP then LOAD
      rx0 = rx_frames;
`ifdef PE_SCHED_STATS_EN
      fc0 = frame_cnt;
      dr0 = drop_cnt;
`endif
      push(8'hAA, NO_OP, w);
      c0 = cyc_cnt;
      push(8'h01, LOAD, w);
      wait_tx_low(10, n);
      chk("t5_start_edges_after_noop", cyc_cnt - c0, 2);
      @(posedge clk); #2;
      wait_idle(200);
      chk("t5_frames_sent", rx_frames - rx0, 1);
`ifdef PE_SCHED_STATS_EN
      chk("t5_drop_delta", drop_cnt - dr0, 1);
      chk("t5_frame_delta", frame_cnt - fc0, 1);
`endif

      // Reset in the middle of the opcode field with commands pending
      push(8'h33, MUL, w);
      push(8'h44, ADD, w);
      push(8'h55, LOAD, w);
      wait_tx_low(10, n);
      repeat (12) @(negedge clk);
      #2;
      nRst = 1'b0;
      #1;
      chk("t1_tx_in_reset", tx, 1);
      chk("t1_busy_in_reset", busy, 0);
      chk("t1_ready_in_reset", cmd_ready, 1);
      repeat (2) @(posedge clk);
      #2;
      nRst = 1'b1;
      @(negedge clk);
      chk("t1_busy_after", busy, 0);
      chk("t1_tx_after", tx, 1);
      @(posedge clk); #2;

      // Randomized traffic
      for (int i = 0; i < 2500; i++) begin
         int r;
         cmd_valid = ($urandom_range(0, 99) < 25);
         cmd_addr  = 8'($urandom);
         r = $urandom_range(0, 9);
         if (r < 2)       cmd_op = NO_OP;
         else if (r == 2) cmd_op = OUT_RES;
         else             cmd_op = 3'($urandom_range(0, 6));
         @(posedge clk); #2;
      end
      cmd_valid = 1'b0;
      wait_idle(3000);
      chk("final_rx_pending", rx_exp.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
